// File: rtl/araba_pkg.sv
// Shared types and default constants for the araba_kontrol vehicle controller.
package araba_pkg;

   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_REVERSE_CYCLES  = 8;
   localparam int DEF_TURN_CYCLES     = 6;
   localparam int DEF_BLINK_HALF      = 3;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FORWARD = 3'd1,
      S_BRAKE   = 3'd2,
      S_REVERSE = 3'd3,
      S_TURN_L  = 3'd4,
      S_TURN_R  = 3'd5,
      S_HALT    = 3'd6
   } state_e;

   // Where to go once the car has backed away: left wins if both sides are open.
   function automatic state_e turn_target(input logic left_blk, input logic right_blk);
      if (!left_blk)
         return S_TURN_L;
      else if (!right_blk)
         return S_TURN_R;
      else
         return S_HALT;
   endfunction

endpackage

// File: rtl/araba_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce filter.
module araba_debounce
   import araba_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic filt_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          filt_q;
   logic [CW-1:0] cnt_q;

   // Bring the raw sensor into the clock domain.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sig_i;
         sync2_q <= sync1_q;
      end
   end

   // Accept a new level only after it has disagreed with the filtered value
   // for DEBOUNCE_CYCLES cycles in a row; any agreeing cycle restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_q <= 1'b0;
         cnt_q  <= '0;
      end else if (sync2_q != filt_q) begin
         if (cnt_q == CNT_LAST) begin
            filt_q <= sync2_q;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end else begin
         cnt_q <= '0;
      end
   end

   assign filt_o = filt_q;

endmodule

// File: rtl/araba_kontrol.sv
// Obstacle-avoiding drive controller: filtered sensors feed a motion FSM,
// with headlight pass-through and a hazard blinker.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | ignition off, nothing driven
//   FORWARD | driving forward
//   BRAKE   | one-cycle stop after front obstacle
//   REVERSE | backing up for REVERSE_CYCLES (or until rear blocked)
//   TURN_L  | steering left for TURN_CYCLES
//   TURN_R  | steering right for TURN_CYCLES
//   HALT    | boxed in on both sides, waiting with hazards on
module araba_kontrol
   import araba_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REVERSE_CYCLES  = DEF_REVERSE_CYCLES,
   parameter int TURN_CYCLES     = DEF_TURN_CYCLES,
   parameter int BLINK_HALF      = DEF_BLINK_HALF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sensor1,
   input  logic       sensor2,
   input  logic       sensor3,
   input  logic       sensor4,
   input  logic       sensor5,
   input  logic       sensor6,
   input  logic       sensor7,
   output logic       Out1,
   output logic       Out2,
   output logic       Out3,
   output logic       Out4,
   output logic       Out5,
   output logic       Out6,
   output logic [2:0] state
);

   localparam int TMAX = (REVERSE_CYCLES > TURN_CYCLES) ? REVERSE_CYCLES : TURN_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] REV_LOAD  = TW'(REVERSE_CYCLES - 1);
   localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES - 1);

   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   logic [6:0]    sens;
   logic [6:0]    filt;
   logic          f_front, f_rear, f_left, f_right, f_head, f_haz, f_ign;

   state_e        state_q;
   logic [TW-1:0] timer_q;
   state_e        exit_tgt;

   logic          out5_q;
   logic          haz_act;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_ph_q, blink_ph_d;

   assign sens = {sensor7, sensor6, sensor5, sensor4, sensor3, sensor2, sensor1};

   for (genvar i = 0; i < 7; i++) begin : g_deb
      araba_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk   (clk),
         .rst   (rst),
         .sig_i (sens[i]),
         .filt_o(filt[i])
      );
   end

   assign f_front = filt[0];
   assign f_rear  = filt[1];
   assign f_left  = filt[2];
   assign f_right = filt[3];
   assign f_head  = filt[4];
   assign f_haz   = filt[5];
   assign f_ign   = filt[6];

   assign exit_tgt = turn_target(f_left, f_right);

   // Motion FSM with its phase down-counter; ignition loss overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
      end else if (state_q != S_IDLE && !f_ign) begin
         state_q <= S_IDLE;
         timer_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (f_ign)
                  state_q <= S_FORWARD;
            end
            S_FORWARD: begin
               if (f_front)
                  state_q <= S_BRAKE;
            end
            S_BRAKE: begin
               state_q <= S_REVERSE;
               timer_q <= REV_LOAD;
            end
            S_REVERSE: begin
               if (timer_q == '0 || f_rear) begin
                  state_q <= exit_tgt;
                  timer_q <= (exit_tgt == S_HALT) ? '0 : TURN_LOAD;
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
            S_TURN_L, S_TURN_R: begin
               if (timer_q == '0)
                  state_q <= S_FORWARD;
               else
                  timer_q <= timer_q - TW'(1);
            end
            S_HALT: begin
               if (exit_tgt != S_HALT) begin
                  state_q <= exit_tgt;
                  timer_q <= TURN_LOAD;
               end
            end
            default: begin
               state_q <= S_IDLE;
               timer_q <= '0;
            end
         endcase
      end
   end

   // Headlights follow the filtered request one cycle later.
   always_ff @(posedge clk) begin
      if (rst)
         out5_q <= 1'b0;
      else
         out5_q <= f_head;
   end

   assign haz_act = f_haz || (state_q == S_HALT);

   // Blink phase advances every BLINK_HALF active cycles; idle hazard parks at zero.
   always_comb begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
      if (haz_act) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            blink_ph_d  = blink_ph_q;
         end
      end
   end

   // Blink counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
      end
   end

   assign Out1  = (state_q == S_FORWARD);
   assign Out2  = (state_q == S_REVERSE);
   assign Out3  = (state_q == S_TURN_L);
   assign Out4  = (state_q == S_TURN_R);
   assign Out5  = out5_q;
   assign Out6  = haz_act && !blink_ph_q;
   assign state = state_q;

endmodule

// File: tb/tb_araba_kontrol.sv
// Randomised bench for araba_kontrol against a cycle-level behavioural model.
module tb_araba_kontrol;

   localparam int D  = 4;
   localparam int RC = 8;
   localparam int TC = 6;
   localparam int BH = 3;

   localparam int M_IDLE = 0, M_FWD = 1, M_BRAKE = 2, M_REV = 3;
   localparam int M_TL = 4, M_TR = 5, M_HALT = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] sens;
   logic       Out1, Out2, Out3, Out4, Out5, Out6;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   int m_s1 [7];
   int m_s2 [7];
   int m_f  [7];
   int m_run[7];
   int m_st, m_el, m_o5, m_o6, m_hn, m_hact;

   int hold [7];
   int seen_halt = 0;

   araba_kontrol #(
      .DEBOUNCE_CYCLES(D),
      .REVERSE_CYCLES (RC),
      .TURN_CYCLES    (TC),
      .BLINK_HALF     (BH)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .sensor1(sens[0]),
      .sensor2(sens[1]),
      .sensor3(sens[2]),
      .sensor4(sens[3]),
      .sensor5(sens[4]),
      .sensor6(sens[5]),
      .sensor7(sens[6]),
      .Out1   (Out1),
      .Out2   (Out2),
      .Out3   (Out3),
      .Out4   (Out4),
      .Out5   (Out5),
      .Out6   (Out6),
      .state  (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int exit_of(input int left_blk, input int right_blk);
      if (left_blk == 0) return M_TL;
      if (right_blk == 0) return M_TR;
      return M_HALT;
   endfunction

   // Advance the model by one rising edge given the inputs present at that edge.
   task automatic model_step(input logic r, input logic [6:0] x);
      int fo[7];
      int nx;
      if (r) begin
         for (int i = 0; i < 7; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_f[i] = 0; m_run[i] = 0;
         end
         m_st = M_IDLE; m_el = 0; m_o5 = 0; m_o6 = 0; m_hn = 0; m_hact = 0;
         return;
      end
      for (int i = 0; i < 7; i++) fo[i] = m_f[i];
      for (int i = 0; i < 7; i++) begin
         if (m_s2[i] != m_f[i]) begin
            m_run[i]++;
            if (m_run[i] >= D) begin
               m_f[i]   = m_s2[i];
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
         m_s2[i] = m_s1[i];
         m_s1[i] = int'(x[i]);
      end
      // motion FSM on the filtered values seen before the edge
      nx = m_st;
      if (m_st != M_IDLE && fo[6] == 0) begin
         nx = M_IDLE; m_el = 0;
      end else begin
         case (m_st)
            M_IDLE:  if (fo[6] == 1) nx = M_FWD;
            M_FWD:   if (fo[0] == 1) nx = M_BRAKE;
            M_BRAKE: begin nx = M_REV; m_el = 0; end
            M_REV: begin
               if (m_el == RC - 1 || fo[1] == 1) begin
                  nx = exit_of(fo[2], fo[3]); m_el = 0;
               end else m_el++;
            end
            M_TL, M_TR: begin
               if (m_el == TC - 1) begin nx = M_FWD; m_el = 0; end
               else m_el++;
            end
            M_HALT: begin
               if (exit_of(fo[2], fo[3]) != M_HALT) begin
                  nx = exit_of(fo[2], fo[3]); m_el = 0;
               end
            end
            default: nx = M_IDLE;
         endcase
      end
      m_st = nx;
      m_o5 = fo[4];
      // hazard: count of consecutive active cycles decides the blink level
      if (m_f[5] == 1 || m_st == M_HALT) begin
         m_hn   = (m_hact == 1) ? m_hn + 1 : 0;
         m_hact = 1;
         m_o6   = (((m_hn / BH) % 2) == 0) ? 1 : 0;
      end else begin
         m_hn = 0; m_hact = 0; m_o6 = 0;
      end
   endtask

   task automatic compare_all();
      chk("state", int'(state), m_st);
      chk("Out1",  int'(Out1), (m_st == M_FWD)  ? 1 : 0);
      chk("Out2",  int'(Out2), (m_st == M_REV)  ? 1 : 0);
      chk("Out3",  int'(Out3), (m_st == M_TL)   ? 1 : 0);
      chk("Out4",  int'(Out4), (m_st == M_TR)   ? 1 : 0);
      chk("Out5",  int'(Out5), m_o5);
      chk("Out6",  int'(Out6), m_o6);
      chk("motion_onehot", ($countones({Out1, Out2, Out3, Out4}) <= 1) ? 1 : 0, 1);
      if (m_st == M_HALT) seen_halt++;
   endtask

   // One clock: sample #1 after the edge, update model with the inputs that were applied.
   task automatic cycle();
      @(posedge clk);
      #1;
      model_step(rst, sens);
      compare_all();
   endtask

   task automatic pick_inputs();
      for (int i = 0; i < 7; i++) begin
         if (hold[i] == 0) begin
            case (i)
               6:       sens[i] = ($urandom_range(0, 9) != 0);
               2, 3:    sens[i] = ($urandom_range(0, 9) < 6);
               default: sens[i] = $urandom_range(0, 1) == 1;
            endcase
            hold[i] = $urandom_range(1, 12);
         end else begin
            hold[i]--;
         end
      end
      rst = ($urandom_range(0, 399) == 0);
   endtask

   initial begin
      int k;
      rst  = 1'b1;
      sens = '0;
      for (int i = 0; i < 7; i++) hold[i] = 0;
      repeat (3) cycle();

      // ignition from cycle 0 after reset: forward drive expected on edge 7
      rst     = 1'b0;
      sens[6] = 1'b1;
      k = -1;
      for (int c = 1; c <= 20; c++) begin
         cycle();
         if (k < 0 && Out1 == 1'b1) k = c;
      end
      chk("ign_latency", k, 7);
      chk("ign_state", int'(state), M_FWD);

      // front obstacle glitch of 3 cycles must be rejected
      sens[0] = 1'b1;
      repeat (3) cycle();
      sens[0] = 1'b0;
      repeat (10) cycle();
      chk("glitch_rejected", int'(state), M_FWD);

      // randomised operation
      for (int c = 0; c < 6000; c++) begin
         pick_inputs();
         cycle();
      end

      chk("halt_reached", (seen_halt > 0) ? 1 : 0, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/araba_kontrol.md
ARABA_KONTROL -- requirements
Module: araba_kontrol

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, cycles a synchronised input must hold a new level before its filtered value changes.
REQ-002 Parameter REVERSE_CYCLES, default 8, cycles spent in REVERSE.
REQ-003 Parameter TURN_CYCLES, default 6, cycles spent in TURN_L or TURN_R.
REQ-004 Parameter BLINK_HALF, default 3, hazard blink half-period in cycles.
REQ-005 clk  input  1  system clock; single clock domain, all state on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 sensor1  input  1  front obstacle (1 = blocked).
REQ-008 sensor2  input  1  rear obstacle (1 = blocked).
REQ-009 sensor3  input  1  left side blocked.
REQ-010 sensor4  input  1  right side blocked.
REQ-011 sensor5  input  1  headlight request.
REQ-012 sensor6  input  1  hazard request.
REQ-013 sensor7  input  1  ignition (1 = on).
REQ-014 Out1  output  1  drive forward.
REQ-015 Out2  output  1  drive reverse.
REQ-016 Out3  output  1  steer left.
REQ-017 Out4  output  1  steer right.
REQ-018 Out5  output  1  headlights.
REQ-019 Out6  output  1  hazard lamp (blinking).
REQ-020 state  output  3  current FSM state encoding, for debug.

Function
REQ-021 Each of sensor1..7 SHALL pass a 2-flop synchroniser then a debouncer; filtered value f<n> updates on the edge where the synchronised value has differed from f<n> for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the count.
REQ-022 Raw input change held from cycle 0 SHALL appear on f<n> at cycle 2+DEBOUNCE_CYCLES; FSM reacts on the following edge.
REQ-023 FSM states: IDLE=0, FORWARD=1, BRAKE=2, REVERSE=3, TURN_L=4, TURN_R=5, HALT=6.
REQ-024 f7=0 in any non-IDLE state SHALL force IDLE next edge, overriding every other transition.
REQ-025 IDLE -> FORWARD when f7=1.
REQ-026 FORWARD -> BRAKE when f1=1.
REQ-027 BRAKE lasts exactly 1 cycle, then REVERSE with phase timer loaded to REVERSE_CYCLES-1.
REQ-028 REVERSE exits when timer reaches 0 or f2=1 (rear blocked, immediate exit); exit target: f3=0 -> TURN_L, else f4=0 -> TURN_R, else HALT.
REQ-029 TURN_L/TURN_R last TURN_CYCLES cycles, then FORWARD (if f1 still 1, FORWARD -> BRAKE on next edge per REQ-026).
REQ-030 HALT -> TURN_L when f3=0, else TURN_R when f4=0; left has priority when both clear together.
REQ-031 Out1..Out4 SHALL be Moore-decoded from the state register: Out1=FORWARD, Out2=REVERSE, Out3=TURN_L, Out4=TURN_R; all 0 in IDLE, BRAKE, HALT; at most one asserted.
REQ-032 Out5 SHALL equal f5 registered (one cycle after f5), independent of FSM state and ignition.
REQ-033 Hazard active = f6=1 or state=HALT; while active Out6 toggles every BLINK_HALF cycles starting at 1 on the first active cycle; when inactive Out6=0 and blink counter cleared.
REQ-034 Phase timer width SHALL be $clog2 of max(REVERSE_CYCLES, TURN_CYCLES)+1; no wrap, it holds at 0.

Reset
REQ-035 rst=1 at an edge SHALL set state=IDLE, all Out*=0, synchronisers, filtered values, debounce counters, phase timer and blink counter to 0, regardless of current state.
REQ-036 After rst deasserts, inputs already high SHALL be treated as new changes (full REQ-022 latency applies).

Structure
REQ-037 Package araba_pkg SHALL hold the state enum and the default parameter constants.
REQ-038 Sub-module araba_debounce (synchroniser + debounce, parameter DEBOUNCE_CYCLES) SHALL be instantiated once per sensor input.

Verification
REQ-039 Reset then sensor7=1 from cycle 0 -> Out1=1 at cycle 7 (defaults), state=1.
REQ-040 FORWARD, sensor1 pulse 3 cycles -> no change (debounce rejects); held 4+ -> BRAKE 1 cycle, Out2=1 for 8 cycles, then Out3=1 for 6 cycles, then Out1=1.
REQ-041 REVERSE with sensor3=1, sensor4=1 -> HALT, Out1..4=0, Out6 pattern 1,1,1,0,0,0,...; drop sensor4 -> TURN_R, Out4=1, Out6=0 when hazard inactive.
REQ-042 REVERSE at cycle 3 of 8, sensor2 debounced high -> immediate exit to TURN_L.
REQ-043 sensor7 dropped during TURN_L -> IDLE after debounce latency, all motion outputs 0; Out5 still follows sensor5.
REQ-044 rst asserted for one cycle mid-REVERSE -> all outputs 0 and state=IDLE on next edge.
